// File: rtl/store_merge_if.sv
// Store-side bus between the MEM stage / data SRAM and store_merge.
// The mem_be lane mask exists only when STORE_BE_EN is defined.
interface store_merge_if;
  logic [1:0]  st_op;
  logic [31:0] A;
  logic [31:0] Din;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
`ifdef STORE_BE_EN
  logic [3:0]  mem_be;
`endif

  // Design-side view.
  modport slave (
    input  st_op, A, Din, mem_rdata,
    output busy, done, addr_err, mem_addr, mem_re, mem_we, mem_wdata
`ifdef STORE_BE_EN
    , output mem_be
`endif
  );

  // Pipeline / memory-side view.
  modport master (
    output st_op, A, Din, mem_rdata,
    input  busy, done, addr_err, mem_addr, mem_re, mem_we, mem_wdata
`ifdef STORE_BE_EN
    , input mem_be
`endif
  );
endinterface

// File: rtl/store_merge.sv
// Store aligner for sw/sh/sb. Without byte enables, sub-word stores are a
// read-modify-write on a word-only synchronous SRAM (IDLE->READ->MERGE->WRITE).
// Optional feature macro: STORE_BE_EN -- adds mem_be and writes every store in
// one cycle using replicated data plus a lane mask.
module store_merge (
  input  logic         clk,
  input  logic         reset,
  store_merge_if.slave bus
);

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpSw   = 2'b01;
  localparam logic [1:0] OpSh   = 2'b10;

  typedef enum logic [1:0] {StIdle, StRead, StMerge, StWrite} state_e;

  state_e      state_q;
  logic        busy_q, rd_q, wr_q, addr_err_q;
  logic [31:0] addr_q, din_q, merged_q;
  logic [1:0]  op_q;
  logic        misaligned;
  logic [31:0] merge_word;
  logic [31:0] wdata;

  // Misalignment check on the live request; sb can never be misaligned.
  always_comb begin
    misaligned = 1'b0;
    if (bus.st_op == OpSw) misaligned = (bus.A[1:0] != 2'b00);
    if (bus.st_op == OpSh) misaligned = bus.A[0];
  end

  // Overlay the latched store data onto the word read back from the SRAM.
  always_comb begin
    merge_word = bus.mem_rdata;
    if (op_q == OpSh) begin
      if (addr_q[1]) merge_word[31:16] = din_q[15:0];
      else           merge_word[15:0]  = din_q[15:0];
    end else begin
      unique case (addr_q[1:0])
        2'b00: merge_word[7:0]   = din_q[7:0];
        2'b01: merge_word[15:8]  = din_q[7:0];
        2'b10: merge_word[23:16] = din_q[7:0];
        2'b11: merge_word[31:24] = din_q[7:0];
        default: ;
      endcase
    end
  end

  // Sequencer: state, registered strobes and latched request in one block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_err_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      op_q       <= OpNone;
      merged_q   <= '0;
    end else begin
      addr_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.st_op != OpNone) begin
            if (misaligned) begin
              addr_err_q <= 1'b1;
            end else begin
              addr_q <= bus.A;
              din_q  <= bus.Din;
              op_q   <= bus.st_op;
              busy_q <= 1'b1;
`ifdef STORE_BE_EN
              state_q <= StWrite;
              wr_q    <= 1'b1;
`else
              if (bus.st_op == OpSw) begin
                state_q <= StWrite;
                wr_q    <= 1'b1;
              end else begin
                state_q <= StRead;
                rd_q    <= 1'b1;
              end
`endif
            end
          end
        end
        StRead: begin
          state_q <= StMerge;
          rd_q    <= 1'b0;
        end
        StMerge: begin
          state_q  <= StWrite;
          merged_q <= merge_word;
          wr_q     <= 1'b1;
        end
        StWrite: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          wr_q    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_BE_EN
  logic [3:0] be_mask;

  // Replicate store data across lanes and build the byte-enable mask.
  always_comb begin
    wdata   = din_q;
    be_mask = 4'b1111;
    if (op_q == OpSh) begin
      wdata   = {2{din_q[15:0]}};
      be_mask = addr_q[1] ? 4'b1100 : 4'b0011;
    end else if (op_q != OpSw) begin
      wdata   = {4{din_q[7:0]}};
      be_mask = 4'b0001 << addr_q[1:0];
    end
  end

  assign bus.mem_be = wr_q ? be_mask : 4'b0000;
`else
  // Full words go out untouched; sub-words use the merged read data.
  always_comb begin
    wdata = (op_q == OpSw) ? din_q : merged_q;
  end
`endif

  // Reset gates the strobes in its own cycle so an aborted store has no effect.
  assign bus.busy      = busy_q;
  assign bus.done      = wr_q & ~reset;
  assign bus.mem_we    = wr_q & ~reset;
  assign bus.mem_re    = rd_q & ~reset;
  assign bus.addr_err  = addr_err_q;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.mem_wdata = wr_q ? wdata : 32'h0;

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge with a small word-only SRAM model.
module tb_store_merge;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] sram [16];

  store_merge_if bus ();

  store_merge u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr[3:0]];
    if (bus.mem_we) sram[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.st_op = op;
    bus.A     = a;
    bus.Din   = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 32'h0;
    bus.mem_rdata = 32'h0;
    req(2'b00, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_err", {31'b0, bus.addr_err}, 32'd0);
    check("rst_re", {31'b0, bus.mem_re}, 32'd0);
    check("rst_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst_addr", {2'b0, bus.mem_addr}, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // Aligned sw: one busy cycle, write on cycle +1.
    req(2'b01, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    check("sw_we", {31'b0, bus.mem_we}, 32'd1);
    check("sw_done", {31'b0, bus.done}, 32'd1);
    check("sw_busy", {31'b0, bus.busy}, 32'd1);
    check("sw_addr", {2'b0, bus.mem_addr}, 32'h4);
    check("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    req(2'b00, 32'h0, 32'h0);
    tick();
    check("sw_busy_end", {31'b0, bus.busy}, 32'd0);
    check("sw_we_end", {31'b0, bus.mem_we}, 32'd0);
    check("sw_mem", sram[4], 32'hDEAD_BEEF);

`ifndef STORE_BE_EN
    // sb RMW into lane [23:16].
    sram[4] = 32'h1122_3344;
    req(2'b11, 32'h0000_0012, 32'h0000_00AB);
    tick();
    check("sb_read_re", {31'b0, bus.mem_re}, 32'd1);
    check("sb_read_we", {31'b0, bus.mem_we}, 32'd0);
    check("sb_read_addr", {2'b0, bus.mem_addr}, 32'h4);
    check("sb_read_busy", {31'b0, bus.busy}, 32'd1);
    tick();
    check("sb_merge_re", {31'b0, bus.mem_re}, 32'd0);
    check("sb_merge_we", {31'b0, bus.mem_we}, 32'd0);
    check("sb_merge_busy", {31'b0, bus.busy}, 32'd1);
    tick();
    check("sb_write_we", {31'b0, bus.mem_we}, 32'd1);
    check("sb_write_done", {31'b0, bus.done}, 32'd1);
    check("sb_wdata", bus.mem_wdata, 32'h11AB_3344);
    req(2'b00, 32'h0, 32'h0);
    tick();
    check("sb_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("sb_mem", sram[4], 32'h11AB_3344);

    // sh RMW into upper half, then a back-to-back sh into the lower half.
    sram[4] = 32'h1122_3344;
    req(2'b10, 32'h0000_0012, 32'h0000_BEEF);
    tick();
    check("sh_re", {31'b0, bus.mem_re}, 32'd1);
    tick();
    tick();
    check("sh_we", {31'b0, bus.mem_we}, 32'd1);
    check("sh_wdata", bus.mem_wdata, 32'hBEEF_3344);
    req(2'b10, 32'h0000_0010, 32'h0000_1234);
    tick();
    check("b2b_idle", {31'b0, bus.busy}, 32'd0);
    tick();
    check("b2b_accept_busy", {31'b0, bus.busy}, 32'd1);
    check("b2b_accept_re", {31'b0, bus.mem_re}, 32'd1);
    req(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    check("b2b_wdata", bus.mem_wdata, 32'hBEEF_1234);
    check("b2b_done", {31'b0, bus.done}, 32'd1);
    tick();
    check("b2b_mem", sram[4], 32'hBEEF_1234);
`endif

    // Misaligned sw and sh: one-cycle addr_err, no access, never busy.
    req(2'b01, 32'h0000_0011, 32'h1234_5678);
    tick();
    check("mis_sw_err", {31'b0, bus.addr_err}, 32'd1);
    check("mis_sw_busy", {31'b0, bus.busy}, 32'd0);
    check("mis_sw_re", {31'b0, bus.mem_re}, 32'd0);
    check("mis_sw_we", {31'b0, bus.mem_we}, 32'd0);
    req(2'b00, 32'h0, 32'h0);
    tick();
    check("mis_sw_err_end", {31'b0, bus.addr_err}, 32'd0);
    check("mis_sw_busy_end", {31'b0, bus.busy}, 32'd0);
    req(2'b10, 32'h0000_0013, 32'h0000_5555);
    tick();
    check("mis_sh_err", {31'b0, bus.addr_err}, 32'd1);
    check("mis_sh_busy", {31'b0, bus.busy}, 32'd0);
    req(2'b00, 32'h0, 32'h0);
    tick();

`ifndef STORE_BE_EN
    // Reset during the WRITE cycle of an sb suppresses the write.
    sram[5] = 32'hCAFE_F00D;
    req(2'b11, 32'h0000_0015, 32'h0000_005A);
    tick();
    req(2'b00, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst_mid_we", {31'b0, bus.mem_we}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_mid_addr", {2'b0, bus.mem_addr}, 32'd0);
    check("rst_mid_wdata", bus.mem_wdata, 32'd0);
    check("rst_mid_mem", sram[5], 32'hCAFE_F00D);
    tick();
    check("rst_mid_idle", {31'b0, bus.busy}, 32'd0);
`endif

    // Reset together with a request: nothing is latched.
    reset = 1'b1;
    req(2'b01, 32'h0000_0020, 32'h7777_7777);
    tick();
    reset = 1'b0;
    req(2'b00, 32'h0, 32'h0);
    #1;
    check("rst_req_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_req_addr", {2'b0, bus.mem_addr}, 32'd0);
    tick();
    check("rst_req_we", {31'b0, bus.mem_we}, 32'd0);

`ifdef STORE_BE_EN
    // Byte-enable path: single-cycle sb to the top lane.
    req(2'b11, 32'h0000_0013, 32'h0000_00CD);
    tick();
    check("be_we", {31'b0, bus.mem_we}, 32'd1);
    check("be_re", {31'b0, bus.mem_re}, 32'd0);
    check("be_mask", {28'b0, bus.mem_be}, 32'h8);
    check("be_wdata", bus.mem_wdata, 32'hCDCD_CDCD);
    req(2'b00, 32'h0, 32'h0);
    tick();
    check("be_idle_mask", {28'b0, bus.mem_be}, 32'h0);
    check("be_idle_busy", {31'b0, bus.busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/store_merge.md
# store_merge

Store-side counterpart of the load extender in the P6 MIPS datapath. Accepts sw/sh/sb requests from the MEM stage and aligns the store data to the correct byte lanes. When the data memory has no byte enables, it performs sub-word stores as a read-modify-write on a word-only synchronous SRAM. While the operation is in progress it raises `busy` so the pipeline stalls.

## Interface
- No parameters.
- `clk  in  1`  clock; all state updates on rising edge.
- `reset  in  1`  synchronous, active-high.
- `st_op  in  2`  00 none, 01 sw, 10 sh, 11 sb; sampled only in IDLE.
- `A  in  32`  byte address of the store.
- `Din  in  32`  store data; sh uses Din[15:0], sb uses Din[7:0].
- `busy  out  1`  high whenever state != IDLE; pipeline holds MEM stage while high.
- `done  out  1`  one-cycle pulse in the cycle the memory write is issued.
- `addr_err  out  1`  registered one-cycle pulse on a misaligned request.
- `mem_addr  out  30`  word address (latched A[31:2]).
- `mem_re  out  1`  read strobe; SRAM returns `mem_rdata` on the next cycle.
- `mem_rdata  in  32`  read data from the SRAM.
- `mem_we  out  1`  write strobe.
- `mem_wdata  out  32`  write data.
- `mem_be  out  4`  byte enables. Present only with STORE_BE_EN.

## Operation
- FSM states: IDLE, READ, MERGE, WRITE. Encoding is free.
- IDLE with st_op != 00 and an aligned address:
  - latch A, Din and st_op;
  - sw goes to WRITE;
  - sh/sb go to READ.
- Misaligned requests (sw with A[1:0] != 00, sh with A[0] = 1):
  - no latch, no memory access;
  - `addr_err` is 1 in the next cycle;
  - state stays IDLE.
- READ: `mem_re` = 1, `mem_addr` = latched A[31:2]; go to MERGE.
- MERGE: capture `merged` from `mem_rdata`, replacing only the target lanes; go to WRITE.
  - sb lane select = A[1:0]: 00 → [7:0], 01 → [15:8], 10 → [23:16], 11 → [31:24].
  - sh lane select = A[1]: 0 → [15:0], 1 → [31:16].
- WRITE: `mem_we` = 1, `done` = 1, `mem_wdata` = latched Din (sw) or `merged` (sh/sb); go to IDLE.
- Memory-side outputs (`mem_re`, `mem_we`, `mem_addr`, `mem_wdata`, `done`) are Moore decodes of state plus latched registers, with no combinational path from `st_op`, `A` or `Din`.
- `st_op` presented outside IDLE is ignored. Upstream holds the request stable while `busy` is high, and drops it after `done`.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `done` 0, `addr_err` 0, `mem_re` 0, `mem_we` 0;
  - `mem_addr` 0, `mem_wdata` 0, `merged` 0, latched regs 0.
- Latency from the accept edge:
  - sw: WRITE in cycle +1; `busy` high 1 cycle.
  - sh/sb: READ +1, MERGE +2, WRITE +3; `busy` high 3 cycles.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after WRITE.
- Reset mid-operation: `mem_we` and `mem_re` are gated by `!reset` in that cycle, so no memory side effect occurs. State is IDLE on the next edge and the pending store is discarded.
- Reset and a request in the same cycle: reset wins; nothing is latched.

## Configuration
- `STORE_BE_EN` defined:
  - `mem_be` port exists;
  - sh/sb go IDLE → WRITE directly, and READ/MERGE are never entered;
  - `mem_wdata` is Din replicated to the target lanes (sb: {4{Din[7:0]}}, sh: {2{Din[15:0]}});
  - `mem_be` = lane mask (sb: 0001 << A[1:0]; sh: 0011 or 1100; sw: 1111), 0000 outside WRITE;
  - all stores take 1 busy cycle.
- `STORE_BE_EN` undefined: no `mem_be` port; read-modify-write path as described in Operation.

## Test plan
- Aligned sw: sw, A = 0x00000010, Din = 0xDEADBEEF. Expected: next cycle `mem_we` = 1, `mem_addr` = 0x4, `mem_wdata` = 0xDEADBEEF, `done` = 1; `busy` high exactly 1 cycle.
- sb read-modify-write: word 0x4 holds 0x11223344; sb, A = 0x12, Din = 0x000000AB. Expected: READ, MERGE, WRITE in order; `mem_wdata` = 0x11AB3344; `done` in cycle +3.
- sh read-modify-write: word 0x4 holds 0x11223344; sh, A = 0x12, Din = 0x0000BEEF. Expected: `mem_wdata` = 0xBEEF3344. A second sh with A = 0x10 in the IDLE cycle after WRITE is accepted.
- Misaligned sw: sw, A = 0x11. Expected: `addr_err` pulses for 1 cycle, `mem_re` = `mem_we` = 0 throughout, `busy` stays 0.
- Reset mid-operation: assert `reset` in the WRITE cycle of an sb. Expected: `mem_we` = 0 in that cycle, state IDLE afterward, all outputs at reset values.
- With STORE_BE_EN: sb, A = 0x13, Din = 0xCD. Expected: cycle +1 has `mem_we` = 1, `mem_be` = 1000, `mem_wdata` = 0xCDCDCDCD, and no `mem_re`.
